// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC start sequencer: state encoding, control word
// bit positions and status word layout.
package dac_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_W   = 3;
    localparam int STAT_FAULT_BIT = 3;
    localparam int STAT_CNT_LSB   = 16;
    localparam int STAT_CNT_W     = 16;

    // Assemble the software-visible status word; unused bits read as zero.
    function automatic logic [31:0] pack_status(input seq_state_e st,
                                                input logic       fault,
                                                input logic [15:0] cnt);
        logic [31:0] word;
        word                                = 32'd0;
        word[STAT_STATE_LSB +: STAT_STATE_W] = st;
        word[STAT_FAULT_BIT]                = fault;
        word[STAT_CNT_LSB +: STAT_CNT_W]    = cnt;
        return word;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clock domain through two flops and
// emits a registered one-cycle pulse on each rising edge of the synchronized
// level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic pulse_r;

    // Synchronizer chain, history flop and registered edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            meta_r  <= async_in;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            pulse_r <= sync_r & ~prev_r;
        end
    end

    assign rise_pulse = pulse_r;

endmodule

// File: rtl/dac_start_sequencer.sv
// DAC start-up sequencer: holds the DAC in reset, waits for clock lock,
// optionally aligns to an external sync edge, then enables the datapath.
// Optional feature macro: DAC_START_SYNC_EN (adds WAIT_SYNC and the sync_in
// synchronizer; without it lock leads straight to RUN).
module dac_start_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] ctrl_word,
    input  logic        dac_locked,
    input  logic        sync_in,
    output logic        dac_rst_n,
    output logic        dac_en,
    output logic [31:0] status
);

    localparam logic [15:0] RST_LOAD = RST_CYCLES[15:0];
    localparam logic [23:0] TO_LAST  = 24'(LOCK_TIMEOUT - 1);

    seq_state_e  state_r;
    seq_state_e  next_state_s;
    logic [15:0] hold_cnt_r;
    logic [15:0] next_hold_s;
    logic [23:0] to_cnt_r;
    logic [23:0] next_to_s;
    logic        fault_r;
    logic        next_fault_s;
    logic [15:0] count_r;
    logic [15:0] next_count_s;
    logic        start_q_r;
    logic        armed_r;
    logic        start_edge_s;
    logic        stop_s;
    logic        dac_rst_n_r;
    logic        dac_en_r;
    logic        next_dac_rst_n_s;
    logic        next_dac_en_s;
    logic        unused_ctrl_s;

    assign unused_ctrl_s = ^ctrl_word[31:2];

`ifdef DAC_START_SYNC_EN
    logic sync_pulse_s;

    sync_edge_detect u_sync_edge (
        .clk        (user_clk),
        .rst_n      (user_rst_n),
        .async_in   (sync_in),
        .rise_pulse (sync_pulse_s)
    );
`else
    logic unused_sync_s;
    assign unused_sync_s = sync_in;
`endif

    // armed_r blocks a start level held high across reset release from
    // looking like a fresh edge on the first clock afterwards.
    assign start_edge_s = ctrl_word[CTRL_START_BIT] & ~start_q_r & armed_r;
    assign stop_s       = ctrl_word[CTRL_STOP_BIT];

    // Capture start bit history for edge detection
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            start_q_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            start_q_r <= ctrl_word[CTRL_START_BIT];
            armed_r   <= 1'b1;
        end
    end

    // State register with hold/timeout counters, fault flag and start count
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 16'd0;
            to_cnt_r   <= 24'd0;
            fault_r    <= 1'b0;
            count_r    <= 16'd0;
        end else begin
            state_r    <= next_state_s;
            hold_cnt_r <= next_hold_s;
            to_cnt_r   <= next_to_s;
            fault_r    <= next_fault_s;
            count_r    <= next_count_s;
        end
    end

    // Next-state and counter update; stop overrides everything else
    always_comb begin
        next_state_s = state_r;
        next_hold_s  = hold_cnt_r;
        next_to_s    = to_cnt_r;
        next_fault_s = fault_r;
        next_count_s = count_r;
        if (stop_s) begin
            next_state_s = ST_IDLE;
            next_fault_s = 1'b0;
            next_hold_s  = 16'd0;
            next_to_s    = 24'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FAULT: begin
                    if (start_edge_s) begin
                        next_state_s = ST_RESET;
                        next_hold_s  = RST_LOAD;
                        next_fault_s = 1'b0;
                        next_count_s = count_r + 16'd1;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                ST_RESET: begin
                    if (hold_cnt_r <= 16'd1) begin
                        next_state_s = ST_WAIT_LOCK;
                        next_hold_s  = 16'd0;
                        next_to_s    = 24'd0;
                    end else begin
                        next_hold_s = hold_cnt_r - 16'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (dac_locked) begin
`ifdef DAC_START_SYNC_EN
                        next_state_s = ST_WAIT_SYNC;
`else
                        next_state_s = ST_RUN;
`endif
                        next_to_s = 24'd0;
                    end else if (to_cnt_r >= TO_LAST) begin
                        next_state_s = ST_FAULT;
                        next_fault_s = 1'b1;
                        next_to_s    = 24'd0;
                    end else begin
                        next_to_s = to_cnt_r + 24'd1;
                    end
                end
`ifdef DAC_START_SYNC_EN
                ST_WAIT_SYNC: begin
                    if (!dac_locked) begin
                        next_state_s = ST_FAULT;
                        next_fault_s = 1'b1;
                    end else if (sync_pulse_s) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = state_r;
                    end
                end
`endif
                ST_RUN: begin
                    if (!dac_locked) begin
                        next_state_s = ST_FAULT;
                        next_fault_s = 1'b1;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    next_fault_s = 1'b0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track state_r
    always_comb begin
        next_dac_rst_n_s = 1'b0;
        next_dac_en_s    = 1'b0;
        case (next_state_s)
            ST_WAIT_LOCK, ST_WAIT_SYNC: begin
                next_dac_rst_n_s = 1'b1;
                next_dac_en_s    = 1'b0;
            end
            ST_RUN: begin
                next_dac_rst_n_s = 1'b1;
                next_dac_en_s    = 1'b1;
            end
            default: begin
                next_dac_rst_n_s = 1'b0;
                next_dac_en_s    = 1'b0;
            end
        endcase
    end

    // Output registers; reset drops them asynchronously
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            dac_rst_n_r <= 1'b0;
            dac_en_r    <= 1'b0;
        end else begin
            dac_rst_n_r <= next_dac_rst_n_s;
            dac_en_r    <= next_dac_en_s;
        end
    end

    assign dac_rst_n = dac_rst_n_r;
    assign dac_en    = dac_en_r;
    assign status    = pack_status(state_r, fault_r, count_r);

endmodule

// File: tb/tb_dac_start_sequencer.sv
// Directed bench for dac_start_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=100.
// Follows DAC_START_SYNC_EN the same way the design does.
module tb_dac_start_sequencer;

    logic        user_clk   = 1'b0;
    logic        user_rst_n = 1'b1;
    logic [31:0] ctrl_word  = 32'd0;
    logic        dac_locked = 1'b0;
    logic        sync_in    = 1'b0;
    logic        dac_rst_n;
    logic        dac_en;
    logic [31:0] status;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic en_seen;

    dac_start_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100)
    ) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl_word  (ctrl_word),
        .dac_locked (dac_locked),
        .sync_in    (sync_in),
        .dac_rst_n  (dac_rst_n),
        .dac_en     (dac_en),
        .status     (status)
    );

    always #5 user_clk = ~user_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [31:0] exp_status(input logic [2:0] st, input logic f,
                                               input logic [15:0] cnt);
        return {cnt, 12'd0, f, st};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    // From IDLE/FAULT with dac_locked=1 and ctrl_word[0]=0, walk to RUN.
    task automatic start_to_run();
        ctrl_word = 32'h1;
        tick();
        ctrl_word = 32'h0;
        repeat (4) tick();
        tick();
`ifdef DAC_START_SYNC_EN
        sync_in = 1'b1;
        repeat (4) tick();
        sync_in = 1'b0;
`endif
    endtask

    initial begin
        // Reset state
        #1 user_rst_n = 1'b0;
        repeat (3) tick();
        check("rst_status", status, 32'h0);
        check("rst_dac_rst_n", {31'd0, dac_rst_n}, 32'd0);
        check("rst_dac_en", {31'd0, dac_en}, 32'd0);
        user_rst_n = 1'b1;
        tick();
        check("idle_after_rst", status, exp_status(3'd0, 1'b0, 16'd0));

        // Lock timeout
        ctrl_word = 32'h1;
        tick();
        check("to_reset_entry", status, exp_status(3'd1, 1'b0, 16'd1));
        check("to_reset_dac_rst_n", {31'd0, dac_rst_n}, 32'd0);
        repeat (3) tick();
        check("to_reset_4th", status, exp_status(3'd1, 1'b0, 16'd1));
        tick();
        check("to_wait_lock", status, exp_status(3'd2, 1'b0, 16'd1));
        check("to_wl_dac_rst_n", {31'd0, dac_rst_n}, 32'd1);
        en_seen = 1'b0;
        repeat (99) begin
            tick();
            if (dac_en) en_seen = 1'b1;
        end
        check("to_wl_99", status, exp_status(3'd2, 1'b0, 16'd1));
        tick();
        check("to_fault", status, exp_status(3'd5, 1'b1, 16'd1));
        check("to_en_never", {31'd0, en_seen | dac_en}, 32'd0);
        ctrl_word = 32'h0;
        tick();
        check("fault_held", status, exp_status(3'd5, 1'b1, 16'd1));
        ctrl_word = 32'h1;
        tick();
        check("restart_clears_fault", status, exp_status(3'd1, 1'b0, 16'd2));

        // Start edges during RESET are ignored
        ctrl_word = 32'h0;
        tick();
        ctrl_word = 32'h1;
        tick();
        check("reset_restart_ignored", status, exp_status(3'd1, 1'b0, 16'd2));
        ctrl_word  = 32'h0;
        dac_locked = 1'b1;
        tick();
        tick();
        check("nom_wait_lock", status, exp_status(3'd2, 1'b0, 16'd2));
        tick();
`ifdef DAC_START_SYNC_EN
        check("nom_wait_sync", status, exp_status(3'd3, 1'b0, 16'd2));
        sync_in = 1'b1;
        repeat (3) tick();
        check("nom_ws_before_run", status, exp_status(3'd3, 1'b0, 16'd2));
        check("nom_en_before_run", {31'd0, dac_en}, 32'd0);
        tick();
        sync_in = 1'b0;
`else
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        tick();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
`endif
        check("nom_run", status, exp_status(3'd4, 1'b0, 16'd2));
        check("nom_run_en", {30'd0, dac_rst_n, dac_en}, 32'd3);

        // Stop in RUN
        ctrl_word = 32'h2;
        tick();
        check("stop_idle", status, exp_status(3'd0, 1'b0, 16'd2));
        check("stop_en", {31'd0, dac_en}, 32'd0);

        // Start and stop together
        ctrl_word = 32'h3;
        tick();
        check("start_stop", status, exp_status(3'd0, 1'b0, 16'd2));
        ctrl_word = 32'h1;
        tick();
        check("start_held_no_edge", status, exp_status(3'd0, 1'b0, 16'd2));
        ctrl_word = 32'h0;
        tick();

        // Loss of lock in RUN
        start_to_run();
        check("run2", status, exp_status(3'd4, 1'b0, 16'd3));
        dac_locked = 1'b0;
        tick();
        check("lockloss_fault", status, exp_status(3'd5, 1'b1, 16'd3));
        check("lockloss_en", {31'd0, dac_en}, 32'd0);

        // Reset asserted in RUN
        dac_locked = 1'b1;
        start_to_run();
        check("run3", status, exp_status(3'd4, 1'b0, 16'd4));
        ctrl_word = 32'h1;
        #2 user_rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {30'd0, dac_rst_n, dac_en}, 32'd0);
        check("async_rst_status", status, 32'h0);
        tick();
        user_rst_n = 1'b1;
        tick();
        tick();
        check("held_start_after_rst", status, exp_status(3'd0, 1'b0, 16'd0));
        ctrl_word = 32'h0;
        tick();

        // Start count wrap: preload near the top, then accept three starts
        force dut.count_r = 16'hFFFE;
        #1 release dut.count_r;
        ctrl_word = 32'h1;
        tick();
        check("cnt_ffff", status, exp_status(3'd1, 1'b0, 16'hFFFF));
        ctrl_word = 32'h2;
        tick();
        ctrl_word = 32'h1;
        tick();
        check("cnt_wrap_0", status, exp_status(3'd1, 1'b0, 16'h0000));
        ctrl_word = 32'h2;
        tick();
        ctrl_word = 32'h1;
        tick();
        check("cnt_wrap_1", {16'd0, status[31:16]}, 32'h1);
        ctrl_word = 32'h2;
        tick();
        ctrl_word = 32'h0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
